// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle MIPS control unit.
//   - state_t     : controller state encoding
//   - OP_* / FN_* : supported opcodes and R-type funct codes
//   - ALU_*       : 3-bit ALU operation codes driven on alu_op
//   - SRCB_*      : alu_src_b select values
//   - PCSRC_*     : pc_src select values
//   - opcode_supported(): true for every opcode the controller sequences
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_XOR = 3'b011;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// mc_aludec: combinational R-type funct decoder.
//   funct         in  6 : IR[5:0]
//   alu_op        out 3 : ALU operation for the funct (ADD when illegal)
//   funct_illegal out 1 : funct is not a supported R-type operation
// Build option: MC_XOR_EN enables funct 100110 (xor -> ALU_XOR); without it
// that funct is reported as illegal. This is the only place it is tested.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_illegal
);

    always_comb begin
        alu_op        = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
`ifdef MC_XOR_EN
            FN_XOR: alu_op = ALU_XOR;
`endif
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/execute/memory/write-back and runs a req/ready
// handshake with the shared instruction/data memory.
// Ports:
//   clk, rst (async, active high)
//   opcode[5:0], funct[5:0], zero, mem_ready        : inputs
//   mem_req, mem_we, iord, ir_we, pc_we, pc_src[1:0],
//   alu_src_a, alu_src_b[1:0], alu_op[2:0], reg_we,
//   reg_dst, mem_to_reg, instr_done, illegal         : outputs
// Outputs are combinational from the state register plus the current
// inputs, so they are valid in the same cycle. Build option MC_XOR_EN
// (handled inside mc_aludec) adds the R-type xor instruction.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] funct_alu_op;
    logic       funct_illegal;
    logic       decode_illegal;

    mc_aludec u_aludec (
        .funct         (funct),
        .alu_op        (funct_alu_op),
        .funct_illegal (funct_illegal)
    );

    assign decode_illegal = !opcode_supported(opcode) ||
                            ((opcode == OP_RTYPE) && funct_illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (decode_illegal) begin
                    state_next = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = S_EXEC;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_ADDI:      state_next = S_ADDIEX;
                        OP_J:         state_next = S_JUMP;
                        default:      state_next = S_FETCH;
                    endcase
                end
            end
            // Only lw/sw reach MEMADR, so anything but lw is a store.
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMMSH;
                illegal    = decode_illegal;
                instr_done = decode_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_we      = zero;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // The state register already sits in FETCH during reset, so the
        // selects show FETCH values; only the strobes need forcing low.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller. Each instruction is summarised by a
// reference model into expected per-instruction totals (cycles, strobe
// counts, write-back attributes) and compared with what was observed.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_op;
    logic       reg_we, reg_dst, mem_to_reg, instr_done, illegal;

    int tests  = 0;
    int failed = 0;
    int n_instr = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference funct table: legal flag and ALU code.
    function automatic void ref_funct(input logic [5:0] fn, output bit legal, output logic [2:0] op);
        legal = 1'b1;
        op    = 3'b010;
        case (fn)
            6'b100000: op = 3'b010;
            6'b100010: op = 3'b110;
            6'b100100: op = 3'b000;
            6'b100101: op = 3'b001;
            6'b101010: op = 3'b111;
`ifdef MC_XOR_EN
            6'b100110: op = 3'b011;
`endif
            default:   legal = 1'b0;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Run one instruction: fw = low mem_ready cycles in fetch, dw = in the
    // data access. Observed totals are compared against the model.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int dw);
        bit is_lw, is_sw, is_r, is_beq, is_addi, is_j, fn_ok, legal;
        logic [2:0] exp_alu;
        int exp_cycles, exp_req, exp_we, exp_iord, exp_pcwe, exp_regwe;
        int cyc = 0, fcnt = 0, dcnt = 0;
        int n_req = 0, n_we = 0, n_iord = 0, n_irwe = 0, n_pcwe = 0, n_regwe = 0, n_ill = 0;
        logic obs_dst = 1'bx, obs_m2r = 1'bx;
        logic [2:0] exec_alu = 3'b100, br_alu = 3'b100;
        logic [1:0] np_pcsrc = 2'b11;
        bit done = 0;

        is_lw = (op == 6'b100011); is_sw = (op == 6'b101011);
        is_r = (op == 6'b000000);  is_beq = (op == 6'b000100);
        is_addi = (op == 6'b001000); is_j = (op == 6'b000010);
        ref_funct(fn, fn_ok, exp_alu);
        legal = op_known(op) && (!is_r || fn_ok);

        if (!legal)                       exp_cycles = 2;
        else if (is_lw)                   exp_cycles = 5;
        else if (is_sw || is_r || is_addi) exp_cycles = 4;
        else                              exp_cycles = 3;
        if (legal && (is_lw || is_sw)) exp_cycles += dw;
        exp_cycles += fw;
        exp_iord  = (legal && (is_lw || is_sw)) ? dw + 1 : 0;
        exp_req   = fw + 1 + exp_iord;
        exp_we    = (legal && is_sw) ? dw + 1 : 0;
        exp_pcwe  = 1 + ((legal && is_j) ? 1 : 0) + ((legal && is_beq && z) ? 1 : 0);
        exp_regwe = (legal && (is_lw || is_r || is_addi)) ? 1 : 0;

        @(posedge clk); #1;
        opcode = op; funct = fn; zero = z;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (mem_req) mem_ready = iord ? (dcnt >= dw) : (fcnt >= fw);
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (mem_req) begin
                n_req++;
                if (iord) dcnt++; else fcnt++;
            end
            if (mem_we) n_we++;
            if (iord)   n_iord++;
            if (ir_we)  n_irwe++;
            if (pc_we) begin
                n_pcwe++;
                if (!mem_req) np_pcsrc = pc_src;
            end
            if (reg_we) begin
                n_regwe++;
                obs_dst = reg_dst;
                obs_m2r = mem_to_reg;
            end
            if (illegal) n_ill++;
            if (alu_src_a && alu_src_b == 2'b00 && pc_src == 2'b00) exec_alu = alu_op;
            if (pc_src == 2'b01) br_alu = alu_op;
            if (instr_done) done = 1;
        end
        n_instr++;
        $display("[TB] instr %0d op=%b fn=%b z=%0b fw=%0d dw=%0d cycles=%0d", n_instr, op, fn, z, fw, dw, cyc);
        check("done_seen", 32'(done), 32'd1);
        check("cycles", cyc, exp_cycles);
        check("mem_req_cycles", n_req, exp_req);
        check("mem_we_cycles", n_we, exp_we);
        check("iord_cycles", n_iord, exp_iord);
        check("ir_we_cycles", n_irwe, 1);
        check("pc_we_cycles", n_pcwe, exp_pcwe);
        check("reg_we_cycles", n_regwe, exp_regwe);
        check("illegal_cycles", n_ill, legal ? 0 : 1);
        if (exp_regwe == 1) begin
            check("reg_dst", 32'(obs_dst), 32'(is_r));
            check("mem_to_reg", 32'(obs_m2r), 32'(is_lw));
        end
        if (legal && is_r) check("exec_alu_op", 32'(exec_alu), 32'(exp_alu));
        if (legal && is_beq) check("branch_alu_op", 32'(br_alu), 32'(3'b110));
        if (legal && is_j) check("jump_pc_src", 32'(np_pcsrc), 32'(2'b10));
        if (legal && is_beq && z) check("branch_pc_src", 32'(np_pcsrc), 32'(2'b01));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 32'({mem_req, mem_we, ir_we, pc_we, reg_we, instr_done, illegal}), 32'd0);
        check({tag, "_selects"}, 32'({iord, alu_src_a, alu_src_b, alu_op, pc_src}), 32'({1'b0, 1'b0, 2'b01, 3'b010, 2'b00}));
    endtask

    logic [5:0] r_functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110};
    logic [5:0] r_ops    [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        int guard;
        logic [5:0] rop, rfn;
        rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check_reset_outputs("reset_hold");
        @(posedge clk); @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("post_reset_mem_req", 32'(mem_req), 32'd1);
        check("post_reset_iord", 32'(iord), 32'd0);

        // Directed cases from the test plan.
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw, zero-wait
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);   // sw, 3 wait cycles
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);   // slt
        run_instr(6'b000000, 6'b100010, 1'b0, 1, 0);   // sub
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'b000000, 6'b100110, 1'b0, 0, 0);   // xor (build dependent)
        run_instr(6'b000010, 6'b000000, 1'b0, 2, 0);   // j

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    do rop = 6'($urandom); while (op_known(rop));
                    rfn = 6'($urandom);
                end
                1: begin rop = 6'b000000; rfn = r_functs[$urandom_range(0, 5)]; end
                2: begin rop = 6'b000000; rfn = 6'($urandom); end
                default: begin rop = r_ops[$urandom_range(0, 5)]; rfn = r_functs[$urandom_range(0, 5)]; end
            endcase
            run_instr(rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a lw stalled in the data read.
        @(posedge clk); #1;
        opcode = 6'b100011; funct = 6'b0;
        guard = 0;
        do begin
            @(negedge clk);
            mem_ready = !(mem_req && iord);
            #1;
            guard++;
        end while (!(mem_req && iord) && guard < 20);
        check("reach_memrd", 32'(mem_req && iord), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_no_write", 32'(reg_we), 32'd0);
        check_reset_outputs("mid_reset_edge");
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("release_mem_req", 32'(mem_req), 32'd1);
        check("release_iord", 32'(iord), 32'd0);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);   // addi after reset

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
